// File: rtl/syscon_seq_pkg.sv
// Shared constants for the system reset controller: bus widths, register map,
// STATUS/CTRL bit positions and FSM state encodings.
package syscon_seq_pkg;

  localparam int ADR_WIDTH = 32;
  localparam int DAT_WIDTH = 32;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_SCRATCH  = 2'd2;
  localparam logic [1:0] REG_UNMAPPED = 2'd3;

  localparam int STATUS_SEQ_DONE_BIT = 16;
  localparam int STATUS_CAUSE_SW_BIT = 17;
  localparam int CTRL_SYS_RST_BIT    = 31;

  typedef enum logic [1:0] {
    ST_POR = 2'd0,
    ST_SEQ = 2'd1,
    ST_RUN = 2'd2
  } state_e;

endpackage

// File: rtl/syscon_rst_chan.sv
// One reset channel: follows the sequencer release, stretches software
// requests to SOFT_CLOCKS cycles and is forced high by a system reset.
module syscon_rst_chan #(
  parameter int SOFT_CLOCKS = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic seq_release_i,
  input  logic soft_req_i,
  input  logic force_i,
  output logic rst_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rst_q, rst_d;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    rst_d = ~seq_release_i;
    if (force_i) begin
      cnt_d = '0;
      rst_d = 1'b1;
    end else if (soft_req_i) begin
      cnt_d = CNT_WIDTH'(SOFT_CLOCKS - 1);
      rst_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      rst_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      rst_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rst_q <= rst_d;
    end
  end

  assign rst_o = rst_q;

endmodule

// File: rtl/syscon_seq.sv
// System controller: power-on sequencer releasing N reset channels in
// staggered order, plus a Wishbone slave for soft/system reset and status.
module syscon_seq
  import syscon_seq_pkg::*;
#(
  parameter int N_RESETS       = 4,
  parameter int POR_CLOCKS     = 10,
  parameter int STAGGER_CLOCKS = 4,
  parameter int SOFT_CLOCKS    = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   ref_clk_i,
  input  logic                   ref_rst_n_i,
  output logic                   syscon_clk_o,
  output logic [N_RESETS-1:0]    syscon_rst_o,
  input  logic                   syscon_cyc_i,
  input  logic                   syscon_stb_i,
  input  logic                   syscon_we_i,
  input  logic [ADR_WIDTH-1:0]   syscon_adr_i,
  input  logic [DAT_WIDTH/8-1:0] syscon_sel_i,
  input  logic [DAT_WIDTH-1:0]   syscon_dat_i,
  output logic [DAT_WIDTH-1:0]   syscon_dat_o,
  output logic                   syscon_ack_o,
  output logic                   syscon_err_o
);

  localparam int IDX_W = (N_RESETS > 1) ? $clog2(N_RESETS) : 1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_RESETS-1:0]  rel_q, rel_d;
  logic                 armed_q, armed_d;
  logic                 seq_done_q, seq_done_d;
  logic                 cause_sw_q, cause_sw_d;
  logic                 ack_q, err_q;
  logic [DAT_WIDTH-1:0] dat_q, rd_d, scratch_q, scratch_d, status_w;

  logic                 wb_req, ctrl_wr, sys_rst;
  logic [1:0]           wb_idx;
  logic [N_RESETS-1:0]  soft_req;
  logic                 unused_adr;

  assign syscon_clk_o = ref_clk_i;
  assign unused_adr   = ^{syscon_adr_i[ADR_WIDTH-1:4], syscon_adr_i[1:0]};

  // A new access is only taken once the previous response has dropped.
  assign wb_req   = syscon_cyc_i & syscon_stb_i & ~ack_q & ~err_q;
  assign wb_idx   = syscon_adr_i[3:2];
  assign ctrl_wr  = wb_req & syscon_we_i & (wb_idx == REG_CTRL);
  assign sys_rst  = ctrl_wr & syscon_dat_i[CTRL_SYS_RST_BIT];
  assign soft_req = (ctrl_wr && !sys_rst && state_q == ST_RUN) ?
                    syscon_dat_i[N_RESETS-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rel_d      = rel_q;
    armed_d    = 1'b1;
    seq_done_d = seq_done_q;
    cause_sw_d = cause_sw_q;
    if (sys_rst) begin
      state_d    = ST_POR;
      cnt_d      = '0;
      idx_d      = '0;
      rel_d      = '0;
      seq_done_d = 1'b0;
      cause_sw_d = 1'b1;
    end else begin
      case (state_q)
        // The first edge after external reset only arms the counter, so that
        // both reset sources see channel 0 fall POR_CLOCKS edges later.
        ST_POR: if (armed_q) begin
          if (cnt_q == CNT_WIDTH'(POR_CLOCKS - 1)) begin
            cnt_d    = '0;
            rel_d[0] = 1'b1;
            if (N_RESETS == 1) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d = ST_SEQ;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SEQ: begin
          if (cnt_q == CNT_WIDTH'(STAGGER_CLOCKS - 1)) begin
            cnt_d = '0;
            for (int i = 0; i < N_RESETS; i++) begin
              if (idx_q == IDX_W'(i)) rel_d[i] = 1'b1;
            end
            if (idx_q == IDX_W'(N_RESETS - 1)) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN:  ;
        default: state_d = ST_POR;
      endcase
    end
  end

  always_ff @(posedge ref_clk_i) begin
    if (!ref_rst_n_i) begin
      state_q    <= ST_POR;
      cnt_q      <= '0;
      idx_q      <= '0;
      rel_q      <= '0;
      armed_q    <= 1'b0;
      seq_done_q <= 1'b0;
      cause_sw_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rel_q      <= rel_d;
      armed_q    <= armed_d;
      seq_done_q <= seq_done_d;
      cause_sw_q <= cause_sw_d;
    end
  end

  // Channels see the release mask being registered this edge, so each output
  // falls on the same edge the sequencer decides to release it.
  for (genvar i = 0; i < N_RESETS; i++) begin : g_chan
    syscon_rst_chan #(
      .SOFT_CLOCKS(SOFT_CLOCKS),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chan (
      .clk_i        (ref_clk_i),
      .rst_n_i      (ref_rst_n_i),
      .seq_release_i(rel_d[i]),
      .soft_req_i   (soft_req[i]),
      .force_i      (sys_rst),
      .rst_o        (syscon_rst_o[i])
    );
  end

  always_comb begin
    status_w                      = '0;
    status_w[N_RESETS-1:0]        = syscon_rst_o;
    status_w[STATUS_SEQ_DONE_BIT] = seq_done_q;
    status_w[STATUS_CAUSE_SW_BIT] = cause_sw_q;

    scratch_d = scratch_q;
    if (wb_req && syscon_we_i && wb_idx == REG_SCRATCH) begin
      for (int b = 0; b < DAT_WIDTH / 8; b++) begin
        if (syscon_sel_i[b]) scratch_d[8*b +: 8] = syscon_dat_i[8*b +: 8];
      end
    end

    rd_d = '0;
    if (wb_req && !syscon_we_i) begin
      case (wb_idx)
        REG_STATUS:  rd_d = status_w;
        REG_SCRATCH: rd_d = scratch_q;
        default:     rd_d = '0;
      endcase
    end
  end

  // NOTE: SCRATCH is a single register, not a memory array, so it is cleared
  // by the external reset like every other flop here.
  always_ff @(posedge ref_clk_i) begin
    if (!ref_rst_n_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      scratch_q <= '0;
    end else begin
      ack_q     <= wb_req & (wb_idx != REG_UNMAPPED);
      err_q     <= wb_req & (wb_idx == REG_UNMAPPED);
      dat_q     <= rd_d;
      scratch_q <= scratch_d;
    end
  end

  assign syscon_dat_o = dat_q;
  assign syscon_ack_o = ack_q;
  assign syscon_err_o = err_q;

endmodule

// File: doc/syscon_seq.md
# syscon_seq

Parametrised system controller that turns one reference clock and an external reset into N independently sequenced, active-high reset outputs. After power-on it releases the channels one at a time in staggered order. It exposes a Wishbone slave through which software can pulse per-channel soft resets, restart the whole sequence, and read reset status and cause. It sits at the top of the SoC, between the board clock/reset pins and every bus master, slave and peripheral.

## Interface
- N_RESETS, 4: number of reset channels (1..16).
- POR_CLOCKS, 10: cycles from external reset release to channel 0 release (≥1).
- STAGGER_CLOCKS, 4: cycles between consecutive channel releases (≥1).
- SOFT_CLOCKS, 8: length of a software per-channel reset pulse (≥1).
- CNT_WIDTH, 16: width of all internal counters; every count parameter must be < 2^CNT_WIDTH.
- ref_clk_i  in  1  reference clock; all logic on rising edge.
- ref_rst_n_i  in  1  external reset; synchronous, active-low.
- syscon_clk_o  out  1  equals ref_clk_i, combinational pass-through.
- syscon_rst_o  out  N_RESETS  per-channel reset; active-high.
- syscon_cyc_i, syscon_stb_i, syscon_we_i  in  1  Wishbone classic cycle/strobe/write.
- syscon_adr_i  in  `ADR_WIDTH  byte address; only bits [3:2] are decoded.
- syscon_sel_i  in  `DAT_WIDTH/8  byte selects.
- syscon_dat_i  in  `DAT_WIDTH  write data.
- syscon_dat_o  out  `DAT_WIDTH  read data.
- syscon_ack_o, syscon_err_o  out  1  transfer terminators.

## Operation
- FSM states: POR → SEQ → RUN. A software system reset returns the FSM to POR.
- POR: all syscon_rst_o = 1. The counter runs 0..POR_CLOCKS-1, then the FSM enters SEQ and deasserts channel 0.
- SEQ: channel i deasserts STAGGER_CLOCKS cycles after channel i-1. After the last channel deasserts, the FSM enters RUN and seq_done = 1.
- Registers (word index adr[3:2]):
  - 0 CTRL (W, reads 0):
    - Bit i (i < N_RESETS) = 1 requests a soft reset of channel i.
    - Bit 31 = 1 requests a system reset. It has priority over the channel bits in the same write.
  - 1 STATUS (R, writes ignored but acked): [N_RESETS-1:0] current syscon_rst_o; [16] seq_done; [17] cause_sw.
  - 2 SCRATCH (RW): per-byte write gated by sel_i. Cleared only by ref_rst_n_i.
  - 3: unmapped; the access terminates with err instead of ack.
- Soft reset of channel i:
  - Accepted only in RUN; ignored (but acked) in POR/SEQ.
  - syscon_rst_o[i] = 1 for exactly SOFT_CLOCKS cycles.
  - A re-request while the pulse is active restarts the count.
  - Channels run independently, so simultaneous requests pulse concurrently.
- System reset:
  - All outputs go to 1, seq_done = 0, cause_sw = 1, all soft pulses are cancelled, and the FSM enters POR with its counter at 0.
  - SCRATCH is kept.
  - The Wishbone slave itself is never reset by this; it keeps responding.
- External reset (ref_rst_n_i = 0 at any edge, mid-sequence included):
  - syscon_rst_o = all 1s, FSM = POR with counter 0.
  - seq_done = 0, cause_sw = 0, SCRATCH = 0.
  - ack_o = err_o = 0, dat_o = 0.

## Timing
- Edge 0 is the first rising edge at which ref_rst_n_i is sampled 1.
- syscon_rst_o[0] falls at edge POR_CLOCKS.
- syscon_rst_o[i] falls at edge POR_CLOCKS + i·STAGGER_CLOCKS; seq_done rises at the same edge as the last channel.
- Wishbone:
  - Registered single-cycle response: ack_o/err_o go high one edge after cyc_i & stb_i are sampled, for one cycle.
  - No new response is issued while ack_o/err_o is high (back-to-back accesses take 2 cycles each).
  - dat_o is valid with ack_o and 0 otherwise.
- The CTRL write takes effect at the same edge ack_o rises:
  - Soft reset: rst_o[i] is high from that edge through SOFT_CLOCKS edges.
  - System reset: all outputs are high at that edge, and channel 0 falls POR_CLOCKS edges later.
- STATUS read returns the values registered at the edge the request was sampled.

## Structure
- Shared package/include, extending config.v:
  - Register word indices (CTRL = 0, STATUS = 1, SCRATCH = 2).
  - STATUS bit positions (16, 17).
  - CTRL system-reset bit (31).
  - FSM state encodings.
- Sub-module syscon_rst_chan, instantiated N_RESETS times.
  - Inputs: seq_release, soft_req, force.
  - Output: one registered reset bit.
  - Holds its own SOFT_CLOCKS down-counter.
- The top level holds the FSM, the shared POR/stagger counter and the Wishbone register file.

## Test plan
- Release ref_rst_n_i with defaults → rst_o[0..3] fall at edges 10, 14, 18, 22; seq_done = 1 at edge 22; STATUS reads 0x0001_0000.
- In RUN, write CTRL = 0x5 → rst_o[0] and rst_o[2] high for exactly 8 cycles from the ack edge, other bits stay 0. A second write of 0x1 at cycle 5 extends rst_o[0] to cycle 13.
- Write CTRL = 0x8000_0001 → all rst_o high, seq_done = 0, sequence replays (channel 0 falls 10 edges later), STATUS[17] = 1, SCRATCH unchanged.
- Write SCRATCH = 0xDEADBEEF with sel = 4'b0011 after reset → reads 0x0000BEEF. Access to adr 0xC → err_o = 1, ack_o = 0.
- Write CTRL = 0x2 during SEQ → acked, no effect on release edges.
- Assert ref_rst_n_i low at edge 16 → next edge all rst_o = 1, seq_done = 0, STATUS[17] = 0, SCRATCH = 0; the sequence restarts from edge 0 after release.
